// File: rtl/bp_me_dma_mem_responder_if.sv
// rtl/bp_me_dma_mem_responder_if.sv - BedRock streaming mem cmd/resp channel bundle
interface bp_me_dma_mem_responder_if #(
  parameter int header_width_p = 63,
  parameter int data_width_p   = 64
);
  logic [header_width_p-1:0] mem_cmd_header;
  logic                      mem_cmd_header_v;
  logic                      mem_cmd_header_yumi;
  logic [data_width_p-1:0]   mem_cmd_data;
  logic                      mem_cmd_data_v;
  logic                      mem_cmd_data_yumi;
  logic [header_width_p-1:0] mem_resp_header;
  logic                      mem_resp_header_v;
  logic                      mem_resp_header_ready;
  logic [data_width_p-1:0]   mem_resp_data;
  logic                      mem_resp_data_v;
  logic                      mem_resp_data_ready;

  modport master (
    output mem_cmd_header, mem_cmd_header_v, mem_cmd_data, mem_cmd_data_v,
           mem_resp_header_ready, mem_resp_data_ready,
    input  mem_cmd_header_yumi, mem_cmd_data_yumi, mem_resp_header, mem_resp_header_v,
           mem_resp_data, mem_resp_data_v
  );

  modport slave (
    input  mem_cmd_header, mem_cmd_header_v, mem_cmd_data, mem_cmd_data_v,
           mem_resp_header_ready, mem_resp_data_ready,
    output mem_cmd_header_yumi, mem_cmd_data_yumi, mem_resp_header, mem_resp_header_v,
           mem_resp_data, mem_resp_data_v
  );
endinterface

// File: rtl/bp_me_dma_mem_responder.sv
// rtl/bp_me_dma_mem_responder.sv - block-granular mem endpoint backed by a sync-read dword RAM
// Header layout: {msg_type[3:0], size[2:0], addr[paddr_width_p-1:0], payload[payload_width_p-1:0]}.
module bp_me_dma_mem_responder #(
  parameter int paddr_width_p   = 40,
  parameter int block_width_p   = 512,
  parameter int dword_width_p   = 64,
  parameter int payload_width_p = 16,
  parameter int mem_els_p       = 4096,
  localparam int beats_lp        = block_width_p / dword_width_p,
  localparam int lg_beats_lp     = $clog2(beats_lp),
  localparam int lg_els_lp       = $clog2(mem_els_p),
  localparam int header_width_lp = 4 + 3 + paddr_width_p + payload_width_p
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  bp_me_dma_mem_responder_if.slave      mem,
  output logic                          error_o
);

  localparam logic [3:0] e_mem_rd = 4'd0;
  localparam logic [3:0] e_mem_wr = 4'd1;
  localparam logic [lg_beats_lp:0] last_beat_lp = (lg_beats_lp+1)'(beats_lp - 1);
  localparam logic [lg_beats_lp:0] all_beats_lp = (lg_beats_lp+1)'(beats_lp);

  typedef enum logic [2:0] {e_idle, e_wr_data, e_wr_resp, e_rd_hdr, e_rd_data} state_e;

  state_e                       state;
  logic                         live;
  logic [header_width_lp-1:0]   hdr_r;
  logic [lg_beats_lp:0]         cnt;
  logic [lg_beats_lp-1:0]       sent;
  logic                         data_full;
  logic [dword_width_p-1:0]     data_q;
  logic [dword_width_p-1:0]     ram [mem_els_p];
  logic [lg_els_lp-1:0]         idx;
  logic [3:0]                   cmd_type;
  logic                         drain;
  logic                         issue;

  assign cmd_type = mem.mem_cmd_header[header_width_lp-1 -: 4];
  // Block-aligned base from the latched address, beat offset from cnt; wraps naturally at mem_els_p.
  assign idx = {hdr_r[payload_width_p+3+lg_beats_lp +: lg_els_lp-lg_beats_lp], cnt[lg_beats_lp-1:0]};

  assign mem.mem_cmd_header_yumi = live & (state == e_idle) & mem.mem_cmd_header_v;
  assign mem.mem_cmd_data_yumi   = (state == e_wr_data) & mem.mem_cmd_data_v;
  assign mem.mem_resp_header_v   = (state == e_wr_resp) | (state == e_rd_hdr);
  assign mem.mem_resp_header     = hdr_r;
  assign mem.mem_resp_data_v     = (state == e_rd_data) & data_full;
  assign mem.mem_resp_data       = data_q;

  assign drain = mem.mem_resp_data_v & mem.mem_resp_data_ready;
  // data_q is the single output slot; refill it whenever it is empty or leaving this cycle.
  assign issue = ((state == e_rd_hdr) & (cnt == '0))
               | ((state == e_rd_data) & (cnt != all_beats_lp) & (~data_full | drain));

  always_ff @(posedge clk_i) begin
    if (mem.mem_cmd_data_yumi) ram[idx] <= mem.mem_cmd_data;
    if (issue)                 data_q   <= ram[idx];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= e_idle;
      live      <= 1'b0;
      hdr_r     <= '0;
      cnt       <= '0;
      sent      <= '0;
      data_full <= 1'b0;
      error_o   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (issue)      data_full <= 1'b1;
      else if (drain) data_full <= 1'b0;

      case (state)
        e_idle: begin
          if (mem.mem_cmd_header_yumi) begin
            hdr_r <= mem.mem_cmd_header;
            if (cmd_type == e_mem_wr) begin
              state <= e_wr_data;
            end else begin
              state <= e_rd_hdr;
              if (cmd_type != e_mem_rd) error_o <= 1'b1;
            end
          end
        end
        e_wr_data: begin
          if (mem.mem_cmd_data_yumi) begin
            if (cnt == last_beat_lp) begin
              cnt   <= '0;
              state <= e_wr_resp;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        e_wr_resp: begin
          if (mem.mem_resp_header_ready) state <= e_idle;
        end
        e_rd_hdr: begin
          if (issue) cnt <= cnt + 1'b1;
          if (mem.mem_resp_header_ready) state <= e_rd_data;
        end
        e_rd_data: begin
          if (issue) cnt <= cnt + 1'b1;
          if (drain) begin
            sent <= sent + 1'b1;
            if (sent == last_beat_lp[lg_beats_lp-1:0]) begin
              state <= e_idle;
              cnt   <= '0;
              sent  <= '0;
            end
          end
        end
        default: state <= e_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_me_dma_mem_responder.sv
// tb/tb_bp_me_dma_mem_responder.sv - directed bench for the DMA mem responder
module tb_bp_me_dma_mem_responder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic error;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] blk  [8];
  logic [63:0] dblk [8];
  logic [63:0] oblk [8];
  logic [63:0] nblk [8];
  logic [63:0] fblk [8];

  always #5 clk = ~clk;

  bp_me_dma_mem_responder_if #(.header_width_p(63), .data_width_p(64)) bus ();

  bp_me_dma_mem_responder dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .mem       (bus),
    .error_o   (error)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [62:0] mk_hdr(input logic [3:0] t, input logic [39:0] a);
    return {t, 3'd6, a, 16'h5a5a};
  endfunction

  task automatic do_write(input logic [39:0] addr);
    logic [62:0] h;
    h = mk_hdr(4'd1, addr);
    @(posedge clk); #1;
    bus.mem_cmd_header = h; bus.mem_cmd_header_v = 1'b1;
    bus.mem_cmd_data = blk[0]; bus.mem_cmd_data_v = 1'b1;
    @(negedge clk);
    check_eq("wr_hdr_yumi", bus.mem_cmd_header_yumi, 1);
    check_eq("wr_data_idle_yumi", bus.mem_cmd_data_yumi, 0);
    @(posedge clk); #1 bus.mem_cmd_header_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("wr_data_yumi", bus.mem_cmd_data_yumi, 1);
      check_eq("wr_resp_early", bus.mem_resp_header_v, 0);
      @(posedge clk); #1;
      if (i < 7) bus.mem_cmd_data = blk[i+1];
      else       bus.mem_cmd_data_v = 1'b0;
    end
    @(negedge clk);
    check_eq("wr_resp_v", bus.mem_resp_header_v, 1);
    check_eq("wr_resp_hdr", bus.mem_resp_header, h);
    check_eq("wr_hdr_busy_yumi", bus.mem_cmd_header_yumi, 0);
  endtask

  task automatic do_read(input logic [3:0] t, input logic [39:0] addr, input bit toggle);
    logic [62:0] h;
    logic [63:0] held;
    int got;
    bit stalled;
    h = mk_hdr(t, addr);
    @(posedge clk); #1;
    bus.mem_cmd_header = h; bus.mem_cmd_header_v = 1'b1;
    bus.mem_resp_data_ready = !toggle;
    @(negedge clk);
    check_eq("rd_hdr_yumi", bus.mem_cmd_header_yumi, 1);
    @(posedge clk); #1 bus.mem_cmd_header_v = 1'b0;
    @(negedge clk);
    check_eq("rd_resp_v", bus.mem_resp_header_v, 1);
    check_eq("rd_resp_hdr", bus.mem_resp_header, h);
    check_eq("rd_data_early", bus.mem_resp_data_v, 0);
    check_eq("rd_data_no_yumi", bus.mem_cmd_data_yumi, 0);
    got = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 64 && got < 8; c++) begin
      @(posedge clk); #1;
      if (toggle) bus.mem_resp_data_ready = ~bus.mem_resp_data_ready;
      @(negedge clk);
      if (stalled) check_eq("rd_stall_hold", bus.mem_resp_data, held);
      if (!toggle) check_eq("rd_beat_v", bus.mem_resp_data_v, 1);
      stalled = bus.mem_resp_data_v && !bus.mem_resp_data_ready;
      held = bus.mem_resp_data;
      if (bus.mem_resp_data_v && bus.mem_resp_data_ready) begin
        check_eq("rd_beat", bus.mem_resp_data, blk[got]);
        got++;
      end
    end
    check_eq("rd_beat_count", got, 8);
    bus.mem_resp_data_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      dblk[i] = 64'hD000_0000_0000_0000 | 64'(i);
      oblk[i] = 64'h0ABC_0000_0000_0000 | 64'(i * 3);
      nblk[i] = 64'h4E40_0000_0000_1000 | 64'(i * 7);
      fblk[i] = 64'hF00D_0000_0000_0000 | 64'(i << 8);
    end
    bus.mem_cmd_header = '0; bus.mem_cmd_header_v = 1'b0;
    bus.mem_cmd_data = '0; bus.mem_cmd_data_v = 1'b0;
    bus.mem_resp_header_ready = 1'b1; bus.mem_resp_data_ready = 1'b1;

    #1;
    check_eq("rst_hdr_yumi", bus.mem_cmd_header_yumi, 0);
    check_eq("rst_data_yumi", bus.mem_cmd_data_yumi, 0);
    check_eq("rst_resp_hdr_v", bus.mem_resp_header_v, 0);
    check_eq("rst_resp_data_v", bus.mem_resp_data_v, 0);
    check_eq("rst_error", error, 0);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;

    blk = dblk;
    do_write(40'h1000);
    do_read(4'd0, 40'h1000, 1'b0);
    do_read(4'd0, 40'h1000, 1'b1);

    blk = fblk;
    do_write(40'h8040);
    do_read(4'd0, 40'h40, 1'b0);
    check_eq("err_after_rd_wr", error, 0);

    blk = oblk;
    do_write(40'h2000);
    @(posedge clk); #1;
    bus.mem_cmd_header = mk_hdr(4'd1, 40'h2000); bus.mem_cmd_header_v = 1'b1;
    bus.mem_cmd_data = nblk[0]; bus.mem_cmd_data_v = 1'b1;
    @(posedge clk); #1 bus.mem_cmd_header_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 bus.mem_cmd_data = nblk[i+1];
    end
    bus.mem_cmd_header_v = 1'b1;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_data_yumi", bus.mem_cmd_data_yumi, 0);
    check_eq("mid_rst_hdr_yumi", bus.mem_cmd_header_yumi, 0);
    check_eq("mid_rst_resp_v", bus.mem_resp_header_v, 0);
    check_eq("mid_rst_data_v", bus.mem_resp_data_v, 0);
    @(posedge clk); #1;
    check_eq("mid_rst_hold_yumi", bus.mem_cmd_data_yumi, 0);
    bus.mem_cmd_header_v = 1'b0; bus.mem_cmd_data_v = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_resp_v", bus.mem_resp_header_v, 0);
    for (int i = 0; i < 8; i++) blk[i] = (i < 3) ? nblk[i] : oblk[i];
    do_read(4'd0, 40'h2000, 1'b0);

    blk = dblk;
    check_eq("err_before_uc", error, 0);
    bus.mem_cmd_data = 64'hBAD0_BAD0_BAD0_BAD0; bus.mem_cmd_data_v = 1'b1;
    do_read(4'd2, 40'h1000, 1'b0);
    check_eq("err_uc_rd", error, 1);
    do_read(4'd5, 40'h1000, 1'b0);
    check_eq("err_amo", error, 1);
    bus.mem_cmd_data_v = 1'b0;
    do_read(4'd0, 40'h1000, 1'b0);
    check_eq("err_sticky", error, 1);

    @(posedge clk); @(negedge clk);
    check_eq("end_idle_data_v", bus.mem_resp_data_v, 0);
    check_eq("end_idle_resp_v", bus.mem_resp_header_v, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
